// File: rtl/switch_event_ctrl_pkg.sv
// Shared sizing, event slot types and index helpers for the switch event controller.
// Imported by the debounce cell and the top level.
package switch_event_ctrl_pkg;

  localparam int NUM_WORDS  = 5;
  localparam int WORD_BITS  = 16;
  localparam int TOTAL_BITS = NUM_WORDS * WORD_BITS;

  localparam int EV_WORD_W  = 3;
  localparam int EV_BIT_W   = 4;
  localparam int FLAT_IDX_W = EV_WORD_W + EV_BIT_W;

  typedef logic [WORD_BITS-1:0]  word_t;
  typedef logic [TOTAL_BITS-1:0] flat_t;
  typedef logic [FLAT_IDX_W-1:0] flat_idx_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  typedef struct packed {
    logic [EV_WORD_W-1:0] word;
    logic [EV_BIT_W-1:0]  bit_idx;
    logic                 level;
  } ev_payload_t;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // WORD_BITS is 16, so word*16+bit is a plain concatenation.
  function automatic flat_idx_t flat_index(input logic [EV_WORD_W-1:0] word,
                                           input logic [EV_BIT_W-1:0]  bit_idx);
    return {word, bit_idx};
  endfunction

  function automatic logic [EV_WORD_W-1:0] word_of(input flat_idx_t idx);
    return idx[FLAT_IDX_W-1:EV_BIT_W];
  endfunction

  function automatic logic [EV_BIT_W-1:0] bit_of(input flat_idx_t idx);
    return idx[EV_BIT_W-1:0];
  endfunction

endpackage

// File: rtl/switch_event_ctrl_bit_debounce.sv
// One switch bit: frame-rate integrator plus the debounced state flop.
// A bit changes only after STABLE_FRAMES consecutive sampled disagreements.
module bit_debounce
  import switch_event_ctrl_pkg::*;
#(
  parameter int STABLE_FRAMES = 4,
  parameter int CNT_W         = width_of(STABLE_FRAMES)
) (
  input  logic clk,
  input  logic resetn,
  input  logic tick,
  input  logic raw,
  output logic sw
);

  logic [CNT_W-1:0] cnt;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_FRAMES - 1);

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
      sw  <= 1'b0;
    end else if (tick) begin
      if (raw == sw) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        sw  <= ~sw;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/switch_event_ctrl.sv
// Debounces five 16-bit 74LV165 snapshots and reports each net bit change
// as a (word, bit, level) event through a single valid/ready slot.
module switch_event_ctrl
  import switch_event_ctrl_pkg::*;
#(
  parameter int FRAME_CYCLES  = 34,
  parameter int STABLE_FRAMES = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [WORD_BITS-1:0] raw_0,
  input  logic [WORD_BITS-1:0] raw_1,
  input  logic [WORD_BITS-1:0] raw_2,
  input  logic [WORD_BITS-1:0] raw_3,
  input  logic [WORD_BITS-1:0] raw_4,
  output logic [WORD_BITS-1:0] sw_0,
  output logic [WORD_BITS-1:0] sw_1,
  output logic [WORD_BITS-1:0] sw_2,
  output logic [WORD_BITS-1:0] sw_3,
  output logic [WORD_BITS-1:0] sw_4,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [EV_WORD_W-1:0] ev_word,
  output logic [EV_BIT_W-1:0]  ev_bit,
  output logic                 ev_level
);

  localparam int FC_W = width_of(FRAME_CYCLES);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_CYCLES - 1);

  logic [FC_W-1:0] frame_cnt;
  logic            tick;

  flat_t raw_flat;
  flat_t sw_flat;
  flat_t reported;
  flat_t pending;

  logic        any_pending;
  flat_idx_t   sel_idx;

  slot_state_t state_q;
  slot_state_t state_d;
  logic        load;
  logic        accept;
  ev_payload_t slot;

  // ---------------------------------------------------------------- frame tick
  assign tick = (frame_cnt == FC_LAST);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      frame_cnt <= '0;
    end else if (tick) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + FC_W'(1);
    end
  end

  // ------------------------------------------------------------ debounce array
  assign raw_flat = {raw_4, raw_3, raw_2, raw_1, raw_0};

  for (genvar gi = 0; gi < TOTAL_BITS; gi++) begin : g_bit
    bit_debounce #(
      .STABLE_FRAMES (STABLE_FRAMES)
    ) u_bit (
      .clk    (clk),
      .resetn (resetn),
      .tick   (tick),
      .raw    (raw_flat[gi]),
      .sw     (sw_flat[gi])
    );
  end

  assign sw_0 = sw_flat[0*WORD_BITS +: WORD_BITS];
  assign sw_1 = sw_flat[1*WORD_BITS +: WORD_BITS];
  assign sw_2 = sw_flat[2*WORD_BITS +: WORD_BITS];
  assign sw_3 = sw_flat[3*WORD_BITS +: WORD_BITS];
  assign sw_4 = sw_flat[4*WORD_BITS +: WORD_BITS];

  // ------------------------------------------------------ pending / priority
  assign pending = sw_flat ^ reported;

  // NOTE: every signal driven here gets a default before the loop; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    any_pending = 1'b0;
    sel_idx     = '0;
    // Scanning downwards lets the lowest pending index win.
    for (int i = TOTAL_BITS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        any_pending = 1'b1;
        sel_idx     = FLAT_IDX_W'(i);
      end
    end
  end

  // ---------------------------------------------------------- handshake slot
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= SLOT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // A slot only refills from EMPTY, so an accepted event always leaves one
  // idle cycle; that cycle lets reported settle before the next selection.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    accept  = 1'b0;
    case (state_q)
      SLOT_EMPTY: begin
        if (any_pending) begin
          load    = 1'b1;
          state_d = SLOT_FULL;
        end
      end
      SLOT_FULL: begin
        if (ev_ready) begin
          accept  = 1'b1;
          state_d = SLOT_EMPTY;
        end
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

  // Payload is captured once and frozen until acceptance; reported takes the
  // offered level, so a bit that moved again meanwhile stays pending.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      slot     <= '0;
      reported <= '0;
    end else begin
      if (load) begin
        slot.word    <= word_of(sel_idx);
        slot.bit_idx <= bit_of(sel_idx);
        slot.level   <= sw_flat[sel_idx];
      end
      if (accept) begin
        reported[flat_index(slot.word, slot.bit_idx)] <= slot.level;
      end
    end
  end

  assign ev_valid = (state_q == SLOT_FULL);
  assign ev_word  = slot.word;
  assign ev_bit   = slot.bit_idx;
  assign ev_level = slot.level;

endmodule

// File: tb/tb_switch_event_ctrl.sv
// Directed bench: default-parameter controller plus a fast FRAME_CYCLES=5 /
// STABLE_FRAMES=2 copy sharing clock and reset.
module tb_switch_event_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [15:0] raw_0, raw_1, raw_2, raw_3, raw_4;
  logic [15:0] sw_0, sw_1, sw_2, sw_3, sw_4;
  logic        ev_valid, ev_ready, ev_level;
  logic [2:0]  ev_word;
  logic [3:0]  ev_bit;

  logic [15:0] f_raw_0, f_raw_1, f_raw_2, f_raw_3, f_raw_4;
  logic [15:0] f_sw_0, f_sw_1, f_sw_2, f_sw_3, f_sw_4;
  logic        f_valid, f_ready, f_level;
  logic [2:0]  f_word;
  logic [3:0]  f_bit;

  switch_event_ctrl u_dut (
    .clk      (clk),
    .resetn   (resetn),
    .raw_0    (raw_0),
    .raw_1    (raw_1),
    .raw_2    (raw_2),
    .raw_3    (raw_3),
    .raw_4    (raw_4),
    .sw_0     (sw_0),
    .sw_1     (sw_1),
    .sw_2     (sw_2),
    .sw_3     (sw_3),
    .sw_4     (sw_4),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_word  (ev_word),
    .ev_bit   (ev_bit),
    .ev_level (ev_level)
  );

  switch_event_ctrl #(
    .FRAME_CYCLES  (5),
    .STABLE_FRAMES (2)
  ) u_fast (
    .clk      (clk),
    .resetn   (resetn),
    .raw_0    (f_raw_0),
    .raw_1    (f_raw_1),
    .raw_2    (f_raw_2),
    .raw_3    (f_raw_3),
    .raw_4    (f_raw_4),
    .sw_0     (f_sw_0),
    .sw_1     (f_sw_1),
    .sw_2     (f_sw_2),
    .sw_3     (f_sw_3),
    .sw_4     (f_sw_4),
    .ev_valid (f_valid),
    .ev_ready (f_ready),
    .ev_word  (f_word),
    .ev_bit   (f_bit),
    .ev_level (f_level)
  );

  int cyc;
  int n_checks;
  int n_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic goto(input int t);
    step(t - cyc);
  endtask

  task automatic watch(input int t, output logic seen);
    seen = 1'b0;
    while (cyc < t) begin
      step(1);
      seen = seen | ev_valid;
    end
  endtask

  task automatic check_offer(input string tag, input logic [2:0] w,
                             input logic [3:0] b, input logic l);
    check({tag, "_valid"}, 32'(ev_valid), 32'd1);
    check({tag, "_word"},  32'(ev_word),  32'(w));
    check({tag, "_bit"},   32'(ev_bit),   32'(b));
    check({tag, "_level"}, 32'(ev_level), 32'(l));
  endtask

  logic seen;

  initial begin
    n_checks = 0;
    n_bad    = 0;
    cyc      = 0;
    resetn   = 1'b0;
    ev_ready = 1'b1;
    f_ready  = 1'b1;
    {raw_0, raw_1, raw_2, raw_3, raw_4}           = '0;
    {f_raw_0, f_raw_1, f_raw_2, f_raw_3, f_raw_4} = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state.
    check("rst_valid", 32'(ev_valid), 32'd0);
    check("rst_word",  32'(ev_word),  32'd0);
    check("rst_bit",   32'(ev_bit),   32'd0);
    check("rst_level", 32'(ev_level), 32'd0);
    check("rst_sw0",   32'(sw_0),     32'd0);
    check("rst_fvalid", 32'(f_valid), 32'd0);

    // Release; cyc counts edges since release, so ticks land on multiples
    // of 34 (main) and 5 (fast).
    raw_0[3]   = 1'b1;
    f_raw_0[0] = 1'b1;
    resetn     = 1'b1;
    cyc        = 0;

    // Fast copy: ticks at 5 and 10, toggle on the second.
    goto(9);
    check("fast_rise_early", 32'(f_sw_0), 32'h0000);
    goto(10);
    check("fast_rise", 32'(f_sw_0), 32'h0001);
    goto(11);
    check("fast_ev_valid", 32'(f_valid), 32'd1);
    check("fast_ev_level", 32'(f_level), 32'd1);
    f_raw_0[0] = 1'b0;
    goto(19);
    check("fast_fall_early", 32'(f_sw_0), 32'h0001);
    goto(20);
    check("fast_fall", 32'(f_sw_0), 32'h0000);

    // Held press: 4th tick is edge 136, offer at 137, accepted at 138.
    goto(135);
    check("press_before_tick4", 32'(sw_0), 32'h0000);
    goto(136);
    check("press_at_tick4", 32'(sw_0), 32'h0008);
    check("press_no_ev_yet", 32'(ev_valid), 32'd0);
    goto(137);
    check_offer("press_offer", 3'd0, 4'd3, 1'b1);
    goto(138);
    check("press_accepted", 32'(ev_valid), 32'd0);

    // Bounce on raw_2[7] across successive ticks 170,204,238,272.
    raw_2[7] = 1'b1;
    goto(170);
    raw_2[7] = 1'b0;
    goto(204);
    raw_2[7] = 1'b1;
    goto(238);
    raw_2[7] = 1'b0;
    watch(306, seen);
    check("bounce_sw2", 32'(sw_2), 32'h0000);
    check("bounce_no_ev", 32'(seen), 32'd0);

    // Simultaneous rises: debounced at 442, lowest flat index first.
    raw_4[15] = 1'b1;
    raw_1[0]  = 1'b1;
    goto(442);
    check("pair_sw1", 32'(sw_1), 32'h0001);
    check("pair_sw4", 32'(sw_4), 32'h8000);
    goto(443);
    check_offer("pair_first", 3'd1, 4'd0, 1'b1);
    goto(444);
    check("pair_gap", 32'(ev_valid), 32'd0);
    goto(445);
    check_offer("pair_second", 3'd4, 4'd15, 1'b1);
    goto(446);
    check("pair_done", 32'(ev_valid), 32'd0);

    // Stalled consumer: press debounced at 578, release debounced at 714.
    ev_ready = 1'b0;
    raw_3[5] = 1'b1;
    goto(579);
    check_offer("stall_offer", 3'd3, 4'd5, 1'b1);
    goto(600);
    raw_3[5] = 1'b0;
    goto(720);
    check("stall_sw3_back", 32'(sw_3), 32'h0000);
    check_offer("stall_frozen", 3'd3, 4'd5, 1'b1);
    goto(1258);
    check_offer("stall_frozen_late", 3'd3, 4'd5, 1'b1);
    ev_ready = 1'b1;
    goto(1259);
    check("stall_accepted", 32'(ev_valid), 32'd0);
    goto(1260);
    check_offer("stall_revert", 3'd3, 4'd5, 1'b0);
    watch(1275, seen);
    check("stall_single_revert", 32'(seen), 32'd0);

    // Releases of three held bits; reset lands while the first is offered.
    ev_ready = 1'b0;
    {raw_0, raw_1, raw_2, raw_3, raw_4} = '0;
    goto(1395);
    check_offer("rst_mid_offer", 3'd0, 4'd3, 1'b0);
    resetn = 1'b0;
    step(1);
    check("rst_mid_valid", 32'(ev_valid), 32'd0);
    check("rst_mid_payload", {28'd0, ev_word, ev_level}, 32'd0);
    check("rst_mid_bit", 32'(ev_bit), 32'd0);
    check("rst_mid_sw", 32'(sw_0 | sw_1 | sw_2 | sw_3 | sw_4), 32'd0);
    resetn   = 1'b1;
    ev_ready = 1'b1;
    cyc      = 0;
    watch(200, seen);
    check("rst_mid_no_ev", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/switch_event_ctrl.md
SWITCH_EVENT_CTRL -- requirements
Module: switch_event_ctrl

Interface
REQ-001 SHALL have parameter FRAME_CYCLES, default 34, meaning clk cycles between samples of the switch snapshot (one full 74LV165 frame).
REQ-002 SHALL have parameter STABLE_FRAMES, default 4, range 2..15, meaning consecutive differing samples required before a bit changes state.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port resetn, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have ports raw_0..raw_4, input, 16 each, raw parallel snapshots from the 74LV165 chain driver.
REQ-006 SHALL have ports sw_0..sw_4, output, 16 each, debounced switch state.
REQ-007 SHALL have port ev_valid, output, 1, an event is offered.
REQ-008 SHALL have port ev_ready, input, 1, the consumer accepts the offered event.
REQ-009 SHALL have port ev_word, output, 3, word index 0..4 of the event.
REQ-010 SHALL have port ev_bit, output, 4, bit index 0..15 of the event.
REQ-011 SHALL have port ev_level, output, 1, new level (1 = press/rising, 0 = release/falling).

Function
REQ-012 SHALL run a free-running frame counter 0..FRAME_CYCLES-1 that wraps, and SHALL assert an internal sample tick when the count equals FRAME_CYCLES-1.
REQ-013 SHALL keep one debounce counter per bit (80 bits), each ceil(log2(STABLE_FRAMES)) bits wide.
REQ-014 On a tick, for each bit where raw equals sw, SHALL clear the counter.
REQ-015 On a tick, for each bit where raw differs from sw and counter = STABLE_FRAMES-1, SHALL toggle sw and clear the counter.
REQ-016 On a tick, for each bit where raw differs from sw otherwise, SHALL increment the counter.
REQ-017 Between ticks, sw and all counters SHALL hold.
REQ-018 SHALL keep an 80-bit reported state; bit i is pending when sw[i] != reported[i].
REQ-019 When the output slot is empty and any bit is pending, SHALL on the next edge load the slot with the lowest pending flat index (word*16+bit), set ev_level = sw of that bit, and assert ev_valid.
REQ-020 While ev_valid=1 and ev_ready=0, ev_word, ev_bit and ev_level SHALL be frozen, even if the underlying sw bit changes again.
REQ-021 On a cycle with ev_valid=1 and ev_ready=1, reported[idx] SHALL be set to ev_level, and ev_valid SHALL be 0 in the following cycle; this gives a maximum throughput of one event per two cycles.
REQ-022 If a bit reverts before its event is accepted, it SHALL not be offered again after acceptance; a bit flipping twice before it is offered SHALL produce no event.
REQ-023 SHALL drop no events: every net sw/reported mismatch SHALL eventually be offered if ev_ready is asserted.
REQ-024 A tick coinciding with acceptance SHALL update sw and reported on the same edge without interference.

Reset
REQ-025 While resetn=0 at a clk edge, the frame counter, all debounce counters, sw_0..sw_4, reported and ev_word/ev_bit/ev_level SHALL be 0, and ev_valid SHALL be 0.
REQ-026 Reset asserted mid-handshake SHALL discard the offered event, and no event SHALL be generated for it after reset.
REQ-027 After reset release, the first tick SHALL occur FRAME_CYCLES cycles later.

Structure
REQ-028 The shared package SHALL hold NUM_WORDS=5, WORD_BITS=16 and the ev_word/ev_bit widths.
REQ-029 The per-bit counter plus sw flop SHALL be one sub-module, bit_debounce, instanced 80 times; priority selection and the handshake slot SHALL stay in the top level.

Verification
REQ-030 Scenario: raw_0[3]=1 held from reset -> sw_0[3] rises at the 4th tick; one event word=0, bit=3, level=1; with ev_ready=1, ev_valid falls after one cycle.
REQ-031 Scenario: raw_2[7] toggles 1,0,1,0 on successive ticks -> sw_2 stays 0 and no event is offered.
REQ-032 Scenario: raw_4[15] and raw_1[0] rise in the same frame -> events are offered in order word1/bit0, then word4/bit15.
REQ-033 Scenario: ev_ready=0 for 20 frames while raw_3[5] goes 1, then back to 0 long enough to debounce -> the offer (3,5,1) stays frozen; after acceptance exactly one further event (3,5,0) is offered.
REQ-034 Scenario: resetn pulsed low for 1 cycle while ev_valid=1 -> all outputs are 0 the next cycle; with raw all zero, no events follow.
REQ-035 Scenario: FRAME_CYCLES=5, STABLE_FRAMES=2 -> a raw change is reflected on sw within 10 cycles, checking counter wrap.
